// File: rtl/line_pingpong_sched.sv
// ============================================================================
// Module   : line_pingpong_sched
// Purpose  : Schedules per-line capture into a two-bank (ping-pong) CIS line
//            RAM. It triggers line writes into a free bank, hands completed
//            banks to the reader in fill order, counts committed and dropped
//            lines per frame, and flags write timeouts and syncs that arrive
//            mid-write.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_pingpong_sched #(
   parameter int               TMO_W   = 20,
   parameter logic [TMO_W-1:0] TMO_MAX = 20'hFFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        scan_en,
   input  logic [15:0] line_total,
   input  logic        line_sync,
   output logic        wr_trigger,
   input  logic        wr_ack,
   output logic        csen,
   output logic        rd_valid,
   output logic        rd_bank,
   input  logic        rd_done,
   output logic [15:0] line_cnt,
   output logic [15:0] drop_cnt,
   output logic        busy,
   output logic        frame_done,
   output logic        err_tmo,
   output logic        err_sync
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARM   = 2'd1,
      S_WRITE = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t           r_state;
   logic [TMO_W-1:0] r_tmo;
   logic [1:0]       r_full;
   logic             r_wr_trigger;
   logic             r_csen;
   logic             r_rd_valid;
   logic             r_rd_bank;
   logic [15:0]      r_line_cnt;
   logic [15:0]      r_drop_cnt;
   logic             r_busy;
   logic             r_frame_done;
   logic             r_err_tmo;
   logic             r_err_sync;

   logic             w_commit;
   logic             w_rd_clr;
   logic [1:0]       w_full_nxt;
   logic             w_rd_bank_nxt;
   logic [15:0]      w_line_inc;
   logic [15:0]      w_drop_inc;

   // Bank occupancy next state: the reader releases its bank while a
   // completed write claims the other one; both can happen in one cycle.
   always_comb begin
      w_commit   = (r_state == S_WRITE) && wr_ack;
      w_rd_clr   = rd_done && r_rd_valid;
      w_full_nxt = r_full;
      if (w_rd_clr) begin
         w_full_nxt[r_rd_bank] = 1'b0;
      end
      if (w_commit) begin
         w_full_nxt[r_csen] = 1'b1;
      end
      w_rd_bank_nxt = w_rd_clr ? ~r_rd_bank : r_rd_bank;
      w_line_inc    = r_line_cnt + 16'd1;
      w_drop_inc    = (r_drop_cnt == 16'hFFFF) ? r_drop_cnt : (r_drop_cnt + 16'd1);
   end

   // Capture FSM plus reader bookkeeping; every output is a register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_tmo        <= '0;
         r_full       <= 2'b00;
         r_wr_trigger <= 1'b0;
         r_csen       <= 1'b0;
         r_rd_valid   <= 1'b0;
         r_rd_bank    <= 1'b0;
         r_line_cnt   <= 16'd0;
         r_drop_cnt   <= 16'd0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_err_tmo    <= 1'b0;
         r_err_sync   <= 1'b0;
      end else begin
         // Reader side runs in every state; rd_valid mirrors the next
         // occupancy of the next read bank so a commit is visible one
         // cycle after wr_ack.
         r_full       <= w_full_nxt;
         r_rd_bank    <= w_rd_bank_nxt;
         r_rd_valid   <= w_full_nxt[w_rd_bank_nxt];
         r_wr_trigger <= 1'b0;
         r_frame_done <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (scan_en) begin
                  r_state    <= S_ARM;
                  r_busy     <= 1'b1;
                  r_line_cnt <= 16'd0;
                  r_drop_cnt <= 16'd0;
                  r_err_tmo  <= 1'b0;
                  r_err_sync <= 1'b0;
               end
            end

            S_ARM: begin
               if (!scan_en) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else if (line_sync) begin
                  if (!r_full[r_csen]) begin
                     r_wr_trigger <= 1'b1;
                     r_tmo        <= '0;
                     r_state      <= S_WRITE;
                  end else begin
                     // Both banks still owned by the reader: the line is lost.
                     r_drop_cnt <= w_drop_inc;
                  end
               end
            end

            S_WRITE: begin
               if (wr_ack) begin
                  r_csen     <= ~r_csen;
                  r_line_cnt <= w_line_inc;
                  if ((line_total != 16'd0) && (w_line_inc == line_total)) begin
                     r_state <= S_DRAIN;
                  end else if (!scan_en) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= S_ARM;
                  end
               end else if (r_tmo == TMO_MAX) begin
                  // Abandon the line; the bank stays free and csen is kept.
                  r_err_tmo <= 1'b1;
                  r_state   <= S_ARM;
               end else begin
                  r_tmo <= r_tmo + TMO_W'(1);
               end
               // A sync while a line is still being written cannot be served.
               if (line_sync) begin
                  r_err_sync <= 1'b1;
                  r_drop_cnt <= w_drop_inc;
               end
            end

            S_DRAIN: begin
               if (r_full == 2'b00) begin
                  r_frame_done <= 1'b1;
                  r_state      <= S_IDLE;
                  r_busy       <= 1'b0;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign wr_trigger = r_wr_trigger;
   assign csen       = r_csen;
   assign rd_valid   = r_rd_valid;
   assign rd_bank    = r_rd_bank;
   assign line_cnt   = r_line_cnt;
   assign drop_cnt   = r_drop_cnt;
   assign busy       = r_busy;
   assign frame_done = r_frame_done;
   assign err_tmo    = r_err_tmo;
   assign err_sync   = r_err_sync;

endmodule

`default_nettype wire

// File: tb/tb_line_pingpong_sched.sv
// ============================================================================
// Module   : tb_line_pingpong_sched
// Purpose  : Self-checking bench for line_pingpong_sched. A transaction-level
//            model (queue of committed banks in fill order) predicts triggers,
//            frame ends and counters; a monitor consumes expected triggers
//            and frame_done pulses from scoreboard queues.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_pingpong_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        scan_en = 1'b0;
   logic [15:0] line_total = 16'd0;
   logic        line_sync = 1'b0;
   logic        wr_ack = 1'b0;
   logic        rd_done = 1'b0;
   logic        wr_trigger, csen, rd_valid, rd_bank, busy, frame_done, err_tmo, err_sync;
   logic [15:0] line_cnt, drop_cnt;

   line_pingpong_sched #(.TMO_W(20), .TMO_MAX(20'd100)) dut (
      .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .line_total(line_total),
      .line_sync(line_sync), .wr_trigger(wr_trigger), .wr_ack(wr_ack),
      .csen(csen), .rd_valid(rd_valid), .rd_bank(rd_bank), .rd_done(rd_done),
      .line_cnt(line_cnt), .drop_cnt(drop_cnt), .busy(busy),
      .frame_done(frame_done), .err_tmo(err_tmo), .err_sync(err_sync)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: mode 0 idle, 1 waiting for sync, 2 line in flight, 3 frame drain
   int m_mode;
   bit m_wbank;
   bit m_rdbank;
   bit m_q[$];          // committed banks, oldest first
   int m_line, m_drop, m_lt, m_wsteps;
   bit m_esync, m_etmo;
   bit exp_trig_q[$];   // expected csen for each upcoming wr_trigger
   int m_fd_pending = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_full(input bit b);
      foreach (m_q[i]) if (m_q[i] == b) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void drop_one();
      if (m_drop < 16'hFFFF) m_drop++;
   endfunction

   function automatic void drain_check();
      if (m_mode == 3 && m_q.size() == 0) begin
         m_fd_pending++;
         m_mode = 0;
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      if (m_mode == 2) m_wsteps++;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   // Scoreboard monitor: every trigger and frame end must have been predicted.
   always @(negedge clk) begin
      if (rst_n && wr_trigger) begin
         if (exp_trig_q.size() == 0) chk("unexpected_trigger", 32'd1, 32'd0);
         else chk("trigger_bank", {31'd0, csen}, {31'd0, exp_trig_q.pop_front()});
      end
      if (rst_n && frame_done) begin
         if (m_fd_pending == 0) chk("unexpected_frame_done", 32'd1, 32'd0);
         else begin
            chk("frame_done_expected", 32'd1, 32'd1 & 32'(m_fd_pending > 0));
            m_fd_pending--;
         end
      end
   end

   task automatic do_reset();
      scan_en = 1'b0; line_sync = 1'b0; wr_ack = 1'b0; rd_done = 1'b0;
      rst_n = 1'b0;
      m_mode = 0; m_wbank = 0; m_rdbank = 0; m_q.delete();
      m_line = 0; m_drop = 0; m_esync = 0; m_etmo = 0; m_wsteps = 0;
      step();
      rst_n = 1'b1;
      chk("rst_outputs", {16'd0, wr_trigger, csen, rd_valid, rd_bank, busy,
                          frame_done, err_tmo, err_sync, 8'd0}, 32'd0);
      chk("rst_line_cnt", {16'd0, line_cnt}, 32'd0);
      chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
   endtask

   task automatic start_frame(input int lt);
      line_total = 16'(lt);
      m_lt = lt;
      scan_en = 1'b1;
      m_mode = 1; m_line = 0; m_drop = 0; m_esync = 0; m_etmo = 0;
      idle(2);
   endtask

   task automatic sync_pulse();
      bit exp_trig;
      exp_trig = 1'b0;
      if (m_mode == 1) begin
         if (is_full(m_wbank)) drop_one();
         else begin
            exp_trig = 1'b1;
            exp_trig_q.push_back(m_wbank);
            m_mode = 2;
            m_wsteps = 0;
         end
      end else if (m_mode == 2) begin
         drop_one();
         m_esync = 1'b1;
      end
      line_sync = 1'b1;
      step();
      line_sync = 1'b0;
      chk("trigger_latency", {31'd0, wr_trigger}, {31'd0, exp_trig});
   endtask

   function automatic void model_rd();
      if (m_q.size() != 0) begin
         m_rdbank = ~m_q.pop_front();
      end
   endfunction

   function automatic void model_ack();
      if (m_mode == 2) begin
         m_q.push_back(m_wbank);
         m_wbank = ~m_wbank;
         m_line = (m_line + 1) & 16'hFFFF;
         if (m_lt != 0 && m_line == m_lt) m_mode = 3;
         else if (!scan_en) m_mode = 0;
         else m_mode = 1;
      end
   endfunction

   task automatic ack_pulse();
      model_ack();
      wr_ack = 1'b1;
      step();
      wr_ack = 1'b0;
      drain_check();
   endtask

   task automatic rd_pulse();
      model_rd();
      rd_done = 1'b1;
      step();
      rd_done = 1'b0;
      drain_check();
   endtask

   task automatic ack_rd_pulse();
      model_rd();
      model_ack();
      wr_ack = 1'b1; rd_done = 1'b1;
      step();
      wr_ack = 1'b0; rd_done = 1'b0;
      drain_check();
   endtask

   task automatic check_state(input string tag);
      bit exp_rb;
      exp_rb = (m_q.size() != 0) ? m_q[0] : m_rdbank;
      chk({tag, "_line_cnt"}, {16'd0, line_cnt}, 32'(m_line));
      chk({tag, "_drop_cnt"}, {16'd0, drop_cnt}, 32'(m_drop));
      chk({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'(m_q.size() != 0));
      chk({tag, "_rd_bank"},  {31'd0, rd_bank},  {31'd0, exp_rb});
      chk({tag, "_csen"},     {31'd0, csen},     {31'd0, m_wbank});
      chk({tag, "_err_sync"}, {31'd0, err_sync}, {31'd0, m_esync});
      chk({tag, "_err_tmo"},  {31'd0, err_tmo},  {31'd0, m_etmo});
   endtask

   initial begin
      int op;
      do_reset();

      // Frame of three lines, reader keeping up, frame end afterwards
      start_frame(3);
      for (int i = 0; i < 3; i++) begin
         sync_pulse();
         idle($urandom_range(5, 48));
         ack_pulse();
         if (i == 2) scan_en = 1'b0;
         idle(1);
         check_state("t1");
         rd_pulse();
         idle(1);
      end
      idle(5);
      chk("t1_busy_after", {31'd0, busy}, 32'd0);
      chk("t1_line_cnt", {16'd0, line_cnt}, 32'd3);
      chk("t1_frame_done_seen", 32'(m_fd_pending), 32'd0);

      // Reader stalled: two lines stored, two dropped, then release one bank
      do_reset();
      start_frame(0);
      for (int i = 0; i < 4; i++) begin
         sync_pulse();
         idle($urandom_range(2, 10));
         ack_pulse();
         idle(1);
      end
      check_state("t2");
      chk("t2_drop2", {16'd0, drop_cnt}, 32'd2);
      rd_pulse();
      chk("t2_rd_bank", {31'd0, rd_bank}, 32'd1);
      sync_pulse();
      idle(3);
      ack_pulse();
      check_state("t2b");

      // Sync during a line write
      do_reset();
      start_frame(0);
      sync_pulse();
      idle(4);
      sync_pulse();
      idle(3);
      ack_pulse();
      check_state("t3");
      chk("t3_err_sync", {31'd0, err_sync}, 32'd1);

      // Write timeout
      do_reset();
      start_frame(0);
      sync_pulse();
      idle(95);
      chk("t4_no_early_tmo", {31'd0, err_tmo}, 32'd0);
      idle(10);
      m_mode = 1; m_etmo = 1'b1;
      check_state("t4");
      chk("t4_busy", {31'd0, busy}, 32'd1);
      sync_pulse();
      idle(2);
      ack_pulse();
      check_state("t4b");

      // Commit and drain in the same cycle
      do_reset();
      start_frame(0);
      sync_pulse();
      idle(3);
      ack_pulse();
      sync_pulse();
      idle(3);
      ack_rd_pulse();
      check_state("t5");
      chk("t5_rd_bank", {31'd0, rd_bank}, 32'd1);
      chk("t5_rd_valid", {31'd0, rd_valid}, 32'd1);

      // Reset during a write, then a stray ack while idle
      do_reset();
      start_frame(0);
      sync_pulse();
      idle(3);
      ack_pulse();
      sync_pulse();
      idle(3);
      do_reset();
      ack_pulse();
      idle(2);
      check_state("t6");
      chk("t6_busy", {31'd0, busy}, 32'd0);

      // Randomised free-running traffic
      do_reset();
      start_frame(0);
      for (int i = 0; i < 120; i++) begin
         op = $urandom_range(0, 3);
         if (m_mode == 2 && m_wsteps > 60) op = 1;
         case (op)
            0: sync_pulse();
            1: ack_pulse();
            2: rd_pulse();
            default: ack_rd_pulse();
         endcase
         idle($urandom_range(0, 3));
         check_state("rand");
      end

      idle(5);
      chk("trigger_queue_empty", 32'(exp_trig_q.size()), 32'd0);
      chk("frame_done_queue_empty", 32'(m_fd_pending), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/line_pingpong_sched.md
Name: line_pingpong_sched

Overview:
- Schedules per-line capture into the two-bank (ping-pong) CIS line RAM.
- Waits for each line sync and checks that the target bank is free. If free, it fires a one-cycle write trigger to the line-RAM write address generator and selects the write bank (CSEN).
- Hands completed banks to the downstream PCIe/DMA reader in order.
- Counts lines per frame and drops lines when both banks are occupied.

Parameters:
TMO_W, 20, width of the write-timeout counter
TMO_MAX, 20'hFFFFF, cycles in WRITE without wr_ack before abort

Ports:
clk  in  1  system clock
rst_n  in  1  reset, active-low
scan_en  in  1  level; enables frame capture
line_total  in  16  lines per frame; 0 = free-running (no frame end)
line_sync  in  1  one-cycle pulse per CIS line start
wr_trigger  out  1  one-cycle pulse to the address generator: start line write
wr_ack  in  1  one-cycle pulse from the address generator: line write complete
csen  out  1  bank being written (0 = bank A, 1 = bank B)
rd_valid  out  1  bank rd_bank holds a complete line
rd_bank  out  1  bank the reader should drain
rd_done  in  1  one-cycle pulse: reader finished rd_bank
line_cnt  out  16  lines committed this frame
drop_cnt  out  16  lines dropped this frame (saturating)
busy  out  1  FSM not in IDLE
frame_done  out  1  one-cycle pulse at frame end
err_tmo  out  1  sticky: write timeout occurred
err_sync  out  1  sticky: line_sync arrived during WRITE

Behaviour:
- Reset: synchronous, active-low, one clock; rst_n low at a rising edge resets all state.
  - All outputs 0; full[1:0] = 0; csen = 0; rd_bank = 0; FSM = IDLE.
  - Reset mid-line abandons the line. The downstream address generator resets on the same rst_n.
- All outputs are registered.
- FSM states: IDLE, ARM, WRITE, DRAIN.
- IDLE:
  - busy = 0.
  - scan_en = 1 -> ARM next cycle.
  - On that IDLE->ARM transition: clear line_cnt, drop_cnt, err_tmo, err_sync.
- ARM:
  - scan_en = 0 -> IDLE.
  - Else, on line_sync with full[csen] = 0: wr_trigger = 1 in the next cycle only (latency 1), tmo counter cleared, -> WRITE.
  - Else, on line_sync with full[csen] = 1: drop_cnt += 1 (saturate at FFFF), stay in ARM, no trigger.
- WRITE:
  - tmo counter increments each cycle.
  - On wr_ack:
    - set full[csen]; toggle csen; line_cnt += 1.
    - If line_total != 0 and new line_cnt == line_total -> DRAIN.
    - Else if scan_en = 0 -> IDLE.
    - Else -> ARM.
  - scan_en falling in WRITE does not abort; the line completes first.
  - line_sync in WRITE: set err_sync, drop_cnt += 1, no other effect.
  - tmo counter == TMO_MAX without wr_ack: set err_tmo, -> ARM. No bank marked full, csen unchanged.
  - wr_ack outside WRITE is ignored.
- DRAIN:
  - Wait until full == 2'b00.
  - Then frame_done = 1 for one cycle, -> IDLE. From IDLE, if scan_en is still 1, the FSM re-arms the following cycle, which starts a new frame.
- Reader side (independent of FSM state, active in all states):
  - rd_valid = full[rd_bank].
  - rd_done while rd_valid = 1: clear full[rd_bank], toggle rd_bank next cycle.
  - rd_done while rd_valid = 0: ignored.
- Commit visibility: wr_ack in cycle M -> rd_valid = 1 in cycle M+1 if rd_bank equals the committed bank.
- Simultaneous wr_ack and rd_done in the same cycle: they address different banks (the write bank was empty at trigger, so it cannot be the one being read). Both updates apply.
- Ordering: banks are always filled and drained alternately, so rd_bank tracks the oldest full bank.
- Width rules:
  - line_cnt wraps at 16 bits in free-running mode.
  - drop_cnt saturates at FFFF.
  - The line_total comparison uses the post-increment value.

Test Plan:
1. scan_en = 1, line_total = 3, reader pulses rd_done 2 cycles after each rd_valid, 3 line_syncs, each wr_ack 50 cycles after trigger -> 3 wr_trigger pulses, each 1 cycle after its sync; csen sequence 0,1,0; line_cnt = 3; frame_done pulses once after the last rd_done; busy = 0 afterwards.
2. Reader stalled (no rd_done), 4 line_syncs, each arriving after the previous line's wr_ack -> 2 triggers, full = 11, drop_cnt = 2. Then rd_done -> rd_bank 0 -> 1; the next line_sync triggers a write to bank 0.
3. line_sync pulsed mid-WRITE -> err_sync = 1, drop_cnt = 1, no second wr_trigger; wr_ack still commits the line.
4. No wr_ack with TMO_MAX = 100 -> err_tmo = 1 after 100 WRITE cycles; FSM in ARM; full = 00; csen unchanged.
5. wr_ack and rd_done in the same cycle (bank 1 committing, bank 0 draining) -> full goes 01 -> 10; rd_bank = 1; rd_valid stays 1.
6. rst_n low for 1 cycle during WRITE with full = 01 -> next cycle all outputs 0, FSM in IDLE. A wr_ack that arrives while the FSM is in IDLE is ignored.
